rs1_exec_alu: RTL and testbench
===============================

Name: rs1_exec_alu

Overview:
- Execute-stage ALU directly downstream of the rs1 operand latch.
- Consumes the latched rs1 value, the rs2 value from the register file, and the decoded immediate; produces one 32-bit result per accepted instruction.
- Handshake: valid/ready on both sides.
- Shifts are iterative, one bit per cycle, to save area; all other operations complete in one cycle.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- SHAMT_W, 5, shift-amount width; equals log2(XLEN).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-low reset (sampled on posedge clk; 0 = reset).
- in_valid  input  1  upstream operands valid.
- in_ready  output  1  block can accept an instruction this cycle.
- opcode  input  7  instruction opcode.
- funct3  input  3  instruction funct3.
- funct7_b5  input  1  instruction bit 30 (SUB/SRA select).
- rs1_data  input  32  rs1 operand from the rs1 latch.
- rs2_data  input  32  rs2 operand from the register file.
- imm  input  32  sign-extended immediate from the decoder.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- result  output  32  ALU result.
- busy  output  1  high while in SHIFT state.

Behaviour:
- Reset (rst==0 at posedge clk): state=IDLE, out_valid=0, result=32'h0, busy=0, internal shift counter=0. in_ready=0 while rst==0.
- Reset taken mid-shift or mid-hold discards the instruction; no result is produced.
- Accept condition: in_valid && in_ready at a posedge clk.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This allows back-to-back issue.
- Operand B select:
  - opcode[6:4]==3'b011 (R-type): rs2_data.
  - All other opcodes: imm.
- Operation select by opcode class:
  - opcode[6:4]==3'b001 or 3'b011: operation by funct3.
  - Any other opcode (loads, stores, JALR): result = rs1 + imm, single cycle.
- funct3 decode for ALU opcodes:
  - 000: ADD; SUB only if R-type and funct7_b5=1; I-type always ADD.
  - 001: SLL.
  - 010: SLT (signed); result = {31'b0, lt}.
  - 011: SLTU (unsigned); result = {31'b0, lt}.
  - 100: XOR.
  - 101: SRL if funct7_b5=0, SRA if funct7_b5=1.
  - 110: OR.
  - 111: AND.
- Arithmetic: modulo 2^32; overflow is ignored.
- Shift amount: operand B[4:0]; upper bits are ignored.
- State machine states: IDLE, SHIFT, DONE.
  - IDLE, accept of a non-shift op: result computed and registered; next state DONE; out_valid=1 the following cycle (latency 1).
  - IDLE, accept of a shift with shamt==0: result=rs1 registered; next state DONE (latency 1).
  - IDLE, accept of a shift with shamt>0: load rs1 into the shift register and the counter with shamt; next state SHIFT; busy=1.
  - SHIFT: each cycle shift by 1 (SLL: zero-fill low; SRL: zero-fill high; SRA: replicate bit31) and decrement the counter. When the counter reaches 1, the final shift is applied and the next state is DONE. Latency from accept to out_valid = shamt+1 cycles.
  - DONE: out_valid=1 and result stable.
    - If !out_ready: hold (stall) indefinitely.
    - If out_ready && new accept: start the new op exactly as from IDLE.
    - If out_ready && no accept: go to IDLE, out_valid=0.
- Operands are captured at accept; input changes afterwards have no effect.
- result holds its last value in IDLE (not cleared).

Optional Feature:
- Macro: RS1_EXEC_BARREL_SHIFT_EN.
- Defined: shifts use a single-cycle barrel shifter. Every op has latency 1; the SHIFT state is never entered; busy stays 0.
- Not defined: iterative shifter as described above; latency shamt+1.

Test Plan:
- Reset: hold rst=0 for 2 cycles with in_valid=1 -> out_valid=0, result=0, in_ready=0, busy=0; after release in_ready=1.
- R-type SUB: opcode=0110011, funct3=000, funct7_b5=1, rs1=5, rs2=7 -> out_valid next cycle, result=32'hFFFFFFFE; ADDI with imm=-1, rs1=0 -> 32'hFFFFFFFF.
- SRAI: opcode=0010011, funct3=101, funct7_b5=1, rs1=32'h80000000, imm=31 -> busy for 31 cycles, out_valid at cycle 32, result=32'hFFFFFFFF. With RS1_EXEC_BARREL_SHIFT_EN: latency 1, same result.
- Backpressure: SLTU rs1=1, rs2=32'hFFFFFFFF (result=1) with out_ready=0 for 5 cycles -> out_valid and result stable, in_ready=0; out_ready=1 with a new ADD 2+3 queued -> next result=5, no bubble.
- Load address: opcode=0000011, rs1=32'h1000, imm=-4 -> result=32'h00000FFC, latency 1.
- Reset mid-shift: SLL rs1=1, shamt=20; assert rst=0 at shift cycle 10 -> state IDLE, out_valid never asserted for that op, result=0.

Source files
------------

// File: rtl/rs1_exec_alu.sv
// rs1_exec_alu: execute-stage ALU fed by the rs1 operand latch, the register-file rs2 and the decoded immediate.
// Latency: 1 cycle for all ops; shifts take shamt+1 cycles (iterative, 1 bit/cycle) unless RS1_EXEC_BARREL_SHIFT_EN is defined.
// Backpressure: the result is held in DONE while out_ready=0; in_ready = IDLE, or DONE with out_ready high (back-to-back issue).
//
// Ports: clk/rst (sync, active-low), in_valid/in_ready + opcode/funct3/funct7_b5/rs1_data/rs2_data/imm upstream,
//        out_valid/out_ready/result downstream, busy = iterative shift in progress.
// Optional macro RS1_EXEC_BARREL_SHIFT_EN: single-cycle barrel shifter; the SHIFT state is never entered.

module rs1_exec_alu #(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [6:0]      opcode,
   input  logic [2:0]      funct3,
   input  logic            funct7_b5,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [XLEN-1:0] imm,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]         state;
   logic [XLEN-1:0]    sh_reg;
   logic [SHAMT_W-1:0] sh_cnt;
   logic               sh_left;
   logic               sh_arith;

   // decode
   logic               is_r;
   logic               is_alu;
   logic               is_shift;
   logic               sub_sel;
   logic [XLEN-1:0]    op_b;
   logic [SHAMT_W-1:0] shamt;
   logic               go_shift;
   logic               accept;
   logic [XLEN-1:0]    shift_res;
   logic [XLEN-1:0]    alu_res;
   logic [XLEN-1:0]    sh_step;
   logic               unused_opcode_lo;

   // Only the opcode class bits matter here; the low bits are decoded upstream.
   assign unused_opcode_lo = ^opcode[3:0];

   assign is_r     = (opcode[6:4] == 3'b011);
   assign is_alu   = (opcode[6:4] == 3'b001) || is_r;
   assign is_shift = is_alu && ((funct3 == 3'b001) || (funct3 == 3'b101));
   assign sub_sel  = is_r && funct7_b5;
   assign op_b     = is_r ? rs2_data : imm;
   assign shamt    = op_b[SHAMT_W-1:0];

`ifdef RS1_EXEC_BARREL_SHIFT_EN
   localparam bit BARREL = 1'b1;
   logic signed [XLEN-1:0] rs1_s;
   assign rs1_s = rs1_data;
   always_comb begin
      shift_res = rs1_data >> shamt;
      if (funct3 == 3'b001) begin
         shift_res = rs1_data << shamt;
      end else if (funct7_b5) begin
         shift_res = rs1_s >>> shamt;
      end
   end
`else
   localparam bit BARREL = 1'b0;
   // Only reached with shamt==0 in this build; nonzero shifts go through SHIFT.
   assign shift_res = rs1_data;
`endif

   assign go_shift  = is_shift && (shamt != '0) && !BARREL;
   assign in_ready  = rst && ((state == S_IDLE) || ((state == S_DONE) && out_ready));
   assign accept    = in_valid && in_ready;
   assign out_valid = (state == S_DONE);
   assign busy      = (state == S_SHIFT);

   always_comb begin
      // Loads, stores, JALR and anything outside the ALU classes form an address.
      alu_res = rs1_data + imm;
      if (is_alu) begin
         case (funct3)
            3'b000:  alu_res = sub_sel ? (rs1_data - op_b) : (rs1_data + op_b);
            3'b001:  alu_res = shift_res;
            3'b010:  alu_res = {{(XLEN-1){1'b0}}, ($signed(rs1_data) < $signed(op_b))};
            3'b011:  alu_res = {{(XLEN-1){1'b0}}, (rs1_data < op_b)};
            3'b100:  alu_res = rs1_data ^ op_b;
            3'b101:  alu_res = shift_res;
            3'b110:  alu_res = rs1_data | op_b;
            default: alu_res = rs1_data & op_b;
         endcase
      end
   end

   // One-bit shift step; SRA replicates the sign bit.
   always_comb begin
      if (sh_left) begin
         sh_step = {sh_reg[XLEN-2:0], 1'b0};
      end else begin
         sh_step = {sh_arith & sh_reg[XLEN-1], sh_reg[XLEN-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= S_IDLE;
         result   <= '0;
         sh_reg   <= '0;
         sh_cnt   <= '0;
         sh_left  <= 1'b0;
         sh_arith <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (accept) begin
                  if (go_shift) begin
                     sh_reg   <= rs1_data;
                     sh_cnt   <= shamt;
                     sh_left  <= (funct3 == 3'b001);
                     sh_arith <= funct7_b5;
                     state    <= S_SHIFT;
                  end else begin
                     result <= alu_res;
                     state  <= S_DONE;
                  end
               end else if ((state == S_DONE) && out_ready) begin
                  state <= S_IDLE;
               end
            end
            S_SHIFT: begin
               sh_reg <= sh_step;
               sh_cnt <= sh_cnt - 1'b1;
               // Counter at 1 means this step is the last one.
               if (sh_cnt == SHAMT_W'(1)) begin
                  result <= sh_step;
                  state  <= S_DONE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rs1_exec_alu.sv
// tb_rs1_exec_alu: directed-vector bench for rs1_exec_alu with hand-computed expectations.
// Latency: checks accept-to-out_valid cycle counts for single-cycle and shift ops.
// Backpressure: holds out_ready low to check result stability and back-to-back issue.

module tb_rs1_exec_alu;

`ifdef RS1_EXEC_BARREL_SHIFT_EN
   localparam bit BARREL = 1'b1;
`else
   localparam bit BARREL = 1'b0;
`endif

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_LD   = 7'b0000011;
   localparam logic [6:0] OP_ST   = 7'b0100011;
   localparam logic [6:0] OP_JALR = 7'b1100111;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [6:0]  opcode = '0;
   logic [2:0]  funct3 = '0;
   logic        funct7_b5 = 1'b0;
   logic [31:0] rs1_data = '0;
   logic [31:0] rs2_data = '0;
   logic [31:0] imm = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] result;
   logic        busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   rs1_exec_alu dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .opcode    (opcode),
      .funct3    (funct3),
      .funct7_b5 (funct7_b5),
      .rs1_data  (rs1_data),
      .rs2_data  (rs2_data),
      .imm       (imm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic int shift_lat(input int n);
      return (BARREL || n == 0) ? 1 : n + 1;
   endfunction

   // Present an instruction and hold it until accepted; operands are scrambled afterwards.
   task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
      int n;
      opcode = op; funct3 = f3; funct7_b5 = f7;
      rs1_data = a; rs2_data = b; imm = im;
      in_valid = 1'b1;
      #1;
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("accept_timeout", 32'(n), 32'd0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      rs1_data = $urandom; rs2_data = $urandom; imm = $urandom;
      funct3 = 3'($urandom); funct7_b5 = 1'($urandom);
   endtask

   // Count cycles from the accept edge until out_valid, then check latency, busy cycles and value.
   task automatic wait_result(input string tag, input logic [31:0] exp, input int exp_lat);
      int lat;
      int bc;
      lat = 1;
      bc  = 0;
      @(negedge clk);
      while (!out_valid && lat < 100) begin
         if (busy) bc++;
         @(negedge clk);
         lat++;
      end
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check({tag, "_busy"}, 32'(bc), 32'(exp_lat - 1));
      check({tag, "_res"}, result, exp);
   endtask

   initial begin
      int ov;
      logic [31:0] held;

      // reset with an instruction offered
      opcode = OP_R; rs1_data = 32'd9; rs2_data = 32'd4; in_valid = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
      check("post_rst_out_valid", 32'(out_valid), 32'd0);

      send(OP_R, 3'b000, 1'b1, 32'd5, 32'd7, 32'd0);
      wait_result("sub", 32'hFFFF_FFFE, 1);
      send(OP_I, 3'b000, 1'b0, 32'd0, 32'd0, 32'hFFFF_FFFF);
      wait_result("addi_m1", 32'hFFFF_FFFF, 1);
      // result holds in IDLE
      held = result;
      @(negedge clk);
      check("idle_out_valid", 32'(out_valid), 32'd0);
      check("idle_hold", result, held);

      send(OP_I, 3'b000, 1'b1, 32'd10, 32'd0, 32'd3);          // I-type never subtracts
      wait_result("addi_f7", 32'd13, 1);
      send(OP_R, 3'b000, 1'b0, 32'd40, 32'd2, 32'd0);
      wait_result("add_r", 32'd42, 1);
      send(OP_I, 3'b101, 1'b1, 32'h8000_0000, 32'd0, 32'd31);
      wait_result("srai31", 32'hFFFF_FFFF, shift_lat(31));
      send(OP_R, 3'b101, 1'b0, 32'h8000_0000, 32'd4, 32'd0);
      wait_result("srl4", 32'h0800_0000, shift_lat(4));
      send(OP_R, 3'b001, 1'b0, 32'd1, 32'h0000_0023, 32'd0);  // shamt uses bits [4:0] only
      wait_result("sll3", 32'd8, shift_lat(3));
      send(OP_R, 3'b101, 1'b1, 32'hDEAD_BEEF, 32'h0000_0020, 32'd0);
      wait_result("sra0", 32'hDEAD_BEEF, 1);
      send(OP_R, 3'b100, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0);
      wait_result("xor", 32'hFF00_FF00, 1);
      send(OP_I, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'd0, 32'd1);
      wait_result("slti", 32'd1, 1);
      send(OP_R, 3'b010, 1'b0, 32'd5, 32'hFFFF_FFFF, 32'd0);
      wait_result("slt", 32'd0, 1);
      send(OP_I, 3'b110, 1'b0, 32'h0000_00F0, 32'd0, 32'h0000_0F0F);
      wait_result("ori", 32'h0000_0FFF, 1);
      send(OP_I, 3'b111, 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FF0F);
      wait_result("andi", 32'h1234_5608, 1);
      send(OP_LD, 3'b010, 1'b0, 32'h0000_1000, 32'd0, 32'hFFFF_FFFC);
      wait_result("load", 32'h0000_0FFC, 1);
      send(OP_ST, 3'b001, 1'b1, 32'h0000_0080, 32'd99, 32'd4);
      wait_result("store", 32'h0000_0084, 1);
      send(OP_JALR, 3'b000, 1'b1, 32'd100, 32'd1, 32'd8);
      wait_result("jalr", 32'd108, 1);

      // backpressure then back-to-back issue
      @(negedge clk);
      out_ready = 1'b0;
      send(OP_R, 3'b011, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd0);
      wait_result("sltu", 32'd1, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_valid", 32'(out_valid), 32'd1);
         check("stall_result", result, 32'd1);
         check("stall_in_ready", 32'(in_ready), 32'd0);
      end
      opcode = OP_R; funct3 = 3'b000; funct7_b5 = 1'b0;
      rs1_data = 32'd2; rs2_data = 32'd3; imm = 32'd0;
      in_valid = 1'b1;
      out_ready = 1'b1;
      #1;
      check("b2b_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      rs1_data = 32'd77;
      @(negedge clk);
      check("b2b_valid", 32'(out_valid), 32'd1);
      check("b2b_result", result, 32'd5);
      @(negedge clk);

      // reset in the middle of a 20-bit shift
      send(OP_I, 3'b001, 1'b0, 32'd1, 32'd0, 32'd20);
      repeat (9) @(posedge clk);
      #1;
      if (!BARREL) check("mid_busy", 32'(busy), 32'd1);
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_result", result, 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      ov = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (out_valid) ov++;
      end
      check("mid_rst_no_result", 32'(ov), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
